minhash_sorter: RTL

Streaming top-K minimum selector between the hasher and the extender. For every fragment it accepts one (signature, index) pair per k-mer from the hasher and keeps the K pairs with the smallest signatures in an ascending-sorted register table. When the fragment's last pair has been absorbed, it presents the K winning FM buffer indices to the extender through a valid/ready handshake. It then clears the table for the next fragment.

---
 rtl/minhash_sorter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/minhash_sorter.sv
// minhash_sorter: streaming top-K minimum selector.
// Keeps the K (sig, idx) pairs with the smallest signatures of a fragment in
// an ascending-sorted register table and hands the winning indices to the
// extender once the fragment's last pair has been absorbed.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_COLLECT | accepting pairs (in_ready=1), table being built
// S_EMIT    | result presented (out_valid=1), waiting for out_ready
module minhash_sorter #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 4,
  parameter int K     = 2,
  parameter int CNT_W = $clog2(K+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIG_W-1:0]     in_sig,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*IDX_W-1:0]   out_idx,
  output logic [CNT_W-1:0]     out_count
);

  typedef enum logic {S_COLLECT = 1'b0, S_EMIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [K-1:0]       vld_q, vld_d;
  logic [SIG_W-1:0]   sig_q [K];
  logic [SIG_W-1:0]   sig_d [K];
  logic [IDX_W-1:0]   idx_q [K];
  logic [IDX_W-1:0]   idx_d [K];
  logic [CNT_W-1:0]   ins_pos;

  // Insertion position: valid entries are a sorted prefix, so counting the
  // ones with sig <= in_sig places ties behind earlier arrivals.
  always_comb begin
    ins_pos = '0;
    for (int j = 0; j < K; j++) begin
      if (vld_q[j] && (sig_q[j] <= in_sig)) ins_pos = ins_pos + CNT_W'(1);
    end
  end

  // Next-state and table update: shift/insert on accept, clear on handshake.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          // Entries below the insertion point move down; slot K-1 falls off.
          for (int i = K-1; i > 0; i--) begin
            if (CNT_W'(i) > ins_pos) begin
              vld_d[i] = vld_q[i-1];
              sig_d[i] = sig_q[i-1];
              idx_d[i] = idx_q[i-1];
            end
          end
          // ins_pos == K matches no slot, so the pair is simply discarded.
          for (int i = 0; i < K; i++) begin
            if (CNT_W'(i) == ins_pos) begin
              vld_d[i] = 1'b1;
              sig_d[i] = in_sig;
              idx_d[i] = in_idx;
            end
          end
          if (in_last) state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          vld_d   = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      vld_q   <= '0;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      for (int i = 0; i < K; i++) begin
        sig_q[i] <= sig_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_EMIT);

  // Result decode from registered table, zero outside EMIT.
  always_comb begin
    out_idx   = '0;
    out_count = '0;
    if (state_q == S_EMIT) begin
      for (int i = 0; i < K; i++) begin
        if (vld_q[i]) begin
          out_idx[IDX_W*i +: IDX_W] = idx_q[i];
          out_count = out_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
